rf_wb_arbiter: RTL and testbench

// Shares the register file's single write port (rf_we/rf_rw/rf_rd) between the in-order pipeline WB stage
// and the long-latency execution unit (mul/div, LU). The pipeline WB stage has priority. LU results queue in an

---
 rtl/rf_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, long-latency results queue in a FIFO,
// a pending-register scoreboard stalls decode, and a starvation counter forces a drain slot.
module rf_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_rd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rw,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rw,
    input  logic [31:0] lu_rd,
    output logic        lu_ready,
    input  logic [4:0]  chk_ra,
    input  logic [4:0]  chk_rb,
    input  logic [4:0]  chk_rw,
    output logic        stall,
    output logic        hold_req,
    output logic        rf_we,
    output logic [4:0]  rf_rw,
    output logic [31:0] rf_rd
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    logic [4:0]       fifo_rw [FIFO_DEPTH];
    logic [31:0]      fifo_rd [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pending;
    logic [31:0]      pending_d;
    logic [STV_W-1:0] starve_cnt;

    logic empty;
    logic full;
    logic wb_slot;
    logic push;
    logic pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign wb_slot = !reset && wb_we && (wb_rw != 5'd0) && !hold_req;
    assign pop     = !reset && !wb_slot && !empty;
    // r0 results are acknowledged to the LU but never stored.
    assign push    = !reset && lu_valid && !full && (lu_rw != 5'd0);

    assign lu_ready = !reset && !full;
    assign stall    = !reset && (pending[chk_ra] | pending[chk_rb] | pending[chk_rw]);

    always_comb begin
        rf_we = 1'b0;
        rf_rw = 5'd0;
        rf_rd = 32'd0;
        if (wb_slot) begin
            rf_we = 1'b1;
            rf_rw = wb_rw;
            rf_rd = wb_rd;
        end else if (pop) begin
            rf_we = 1'b1;
            rf_rw = fifo_rw[rd_ptr];
            rf_rd = fifo_rd[rd_ptr];
        end
    end

    // Clear on drain first so a same-cycle issue to the same register wins.
    always_comb begin
        pending_d = pending;
        if (pop) begin
            pending_d[fifo_rw[rd_ptr]] = 1'b0;
        end
        if (issue_valid && (issue_rw != 5'd0)) begin
            pending_d[issue_rw] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rw[wr_ptr] <= lu_rw;
            fifo_rd[wr_ptr] <= lu_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            starve_cnt <= '0;
            hold_req   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            pending  <= pending_d;
            hold_req <= 1'b0;

            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (wb_slot) begin
                if (starve_cnt == STV_W'(STARVE_MAX - 1)) begin
                    hold_req   <= 1'b1;
                    starve_cnt <= '0;
                end else begin
                    starve_cnt <= starve_cnt + STV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued as stimulus is driven
// and compared in order whenever the port writes.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_rd;
    logic        issue_valid;
    logic [4:0]  issue_rw;
    logic        lu_valid;
    logic [4:0]  lu_rw;
    logic [31:0] lu_rd;
    logic        lu_ready;
    logic [4:0]  chk_ra;
    logic [4:0]  chk_rb;
    logic [4:0]  chk_rw;
    logic        stall;
    logic        hold_req;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_rd;

    logic [36:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .FIFO_DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_we      (wb_we),
        .wb_rw      (wb_rw),
        .wb_rd      (wb_rd),
        .issue_valid(issue_valid),
        .issue_rw   (issue_rw),
        .lu_valid   (lu_valid),
        .lu_rw      (lu_rw),
        .lu_rd      (lu_rd),
        .lu_ready   (lu_ready),
        .chk_ra     (chk_ra),
        .chk_rb     (chk_rb),
        .chk_rw     (chk_rw),
        .stall      (stall),
        .hold_req   (hold_req),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_rd      (rf_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        wb_we       = 1'b0;
        wb_rw       = 5'd0;
        wb_rd       = 32'd0;
        issue_valid = 1'b0;
        issue_rw    = 5'd0;
        lu_valid    = 1'b0;
        lu_rw       = 5'd0;
        lu_rd       = 32'd0;
        chk_ra      = 5'd0;
        chk_rb      = 5'd0;
        chk_rw      = 5'd0;
    endtask

    task automatic expect_wr(input logic [4:0] rw, input logic [31:0] rd);
        exp_q.push_back({rw, rd});
    endtask

    // Every port write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {27'd0, rf_rw, rf_rd}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("wr", {27'd0, rf_rw, rf_rd}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;

        // 1: reset, with junk on the inputs
        wb_we = 1'b1; wb_rw = 5'd8; wb_rd = 32'h88; lu_valid = 1'b1; lu_rw = 5'd9;
        issue_valid = 1'b1; issue_rw = 5'd8; chk_ra = 5'd8;
        settle();
        check("rst_rf_we", rf_we, 0);
        check("rst_lu_ready", lu_ready, 0);
        check("rst_stall", stall, 0);
        tick();
        tick();
        idle();
        reset = 1'b0;
        settle();
        check("t1_rf_we", rf_we, 0);
        check("t1_lu_ready", lu_ready, 1);
        check("t1_stall", stall, 0);
        check("t1_hold", hold_req, 0);

        // 2: WB and LU push together; WB first, LU drains next cycle
        tick();
        issue_valid = 1'b1; issue_rw = 5'd7;
        tick();
        idle();
        wb_we = 1'b1; wb_rw = 5'd5; wb_rd = 32'hA5;
        lu_valid = 1'b1; lu_rw = 5'd7; lu_rd = 32'h77;
        chk_ra = 5'd7;
        expect_wr(5'd5, 32'hA5);
        expect_wr(5'd7, 32'h77);
        settle();
        check("t2_stall_pend", stall, 1);
        check("t2_wb_addr", rf_rw, 5);
        tick();
        idle();
        chk_ra = 5'd7;
        settle();
        check("t2_stall_drain", stall, 1);
        check("t2_drain_addr", rf_rw, 7);
        tick();
        settle();
        check("t2_stall_clr", stall, 0);
        check("t2_idle", rf_we, 0);

        // 3: RAW stall until the LU result drains
        tick();
        idle();
        issue_valid = 1'b1; issue_rw = 5'd9;
        tick();
        idle();
        chk_ra = 5'd9;
        settle();
        check("t3_stall", stall, 1);
        tick();
        lu_valid = 1'b1; lu_rw = 5'd9; lu_rd = 32'h99;
        expect_wr(5'd9, 32'h99);
        settle();
        check("t3_no_bypass", rf_we, 0);
        tick();
        lu_valid = 1'b0;
        settle();
        check("t3_drain", rf_we, 1);
        check("t3_stall_drain", stall, 1);
        tick();
        settle();
        check("t3_stall_clr", stall, 0);

        // 4: FIFO fills behind continuous WB traffic; starvation forces a drain
        for (int i = 0; i < 7; i++) begin
            tick();
            idle();
            wb_we = 1'b1; wb_rw = 5'd3; wb_rd = 32'h30 + 32'(i);
            lu_valid = (i < 6);
            lu_rw = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
            lu_rd = (i == 0) ? 32'h100 : (i == 1) ? 32'h110 : 32'h120;
            if (i == 5) expect_wr(5'd10, 32'h100);
            else        expect_wr(5'd3, 32'h30 + 32'(i));
            settle();
            check("t4_hold", hold_req, (i == 5));
            check("t4_ready", lu_ready, (i < 2) || (i == 6));
        end
        tick();
        idle();
        expect_wr(5'd11, 32'h110);
        settle();
        check("t4_drain", rf_we, 1);
        tick();
        settle();
        check("t4_empty", rf_we, 0);

        // 5: WB to r0 leaves the slot free; LU result for r0 is dropped
        tick();
        lu_valid = 1'b1; lu_rw = 5'd13; lu_rd = 32'h130;
        tick();
        idle();
        wb_we = 1'b1; wb_rw = 5'd0; wb_rd = 32'hDEAD;
        lu_valid = 1'b1; lu_rw = 5'd0; lu_rd = 32'hBAD;
        expect_wr(5'd13, 32'h130);
        settle();
        check("t5_drain", rf_we, 1);
        check("t5_ready", lu_ready, 1);
        tick();
        idle();
        settle();
        check("t5_r0_dropped", rf_we, 0);

        // 6: reset flushes queued entries and pending bits
        tick();
        issue_valid = 1'b1; issue_rw = 5'd4;
        tick();
        idle();
        issue_valid = 1'b1; issue_rw = 5'd6;
        lu_valid = 1'b1; lu_rw = 5'd20; lu_rd = 32'h200;
        tick();
        idle();
        wb_we = 1'b1; wb_rw = 5'd2; wb_rd = 32'h22;
        lu_valid = 1'b1; lu_rw = 5'd21; lu_rd = 32'h210;
        chk_ra = 5'd4; chk_rb = 5'd6;
        expect_wr(5'd2, 32'h22);
        settle();
        check("t6_stall_pre", stall, 1);
        tick();
        idle();
        chk_ra = 5'd4; chk_rb = 5'd6;
        reset = 1'b1;
        settle();
        check("t6_rst_rf_we", rf_we, 0);
        check("t6_rst_stall", stall, 0);
        tick();
        reset = 1'b0;
        settle();
        check("t6_rf_we", rf_we, 0);
        check("t6_stall", stall, 0);
        check("t6_ready", lu_ready, 1);
        tick();
        settle();
        check("t6_still_empty", rf_we, 0);

        tick();
        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
